mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Parametrised single-port synchronous memory slave serving the eightbit core's request/ready bus (addr, mem_req, we, write data in, read data out, mem_ready).
- Generalises the single-cycle behavioural memory into reusable RTL with configurable data width, address width, depth, wait-state latency and a backdoor program-load port.
- Used as the core's main memory in simulation and FPGA builds.

Parameters:
- DATA_W, 8, data bus width in bits.
- ADDR_W, 8, address bus width in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- LATENCY, 0, wait states between request acceptance and the mem_ready pulse (0..15).
- INIT_FILE, "", hex file loaded into the array at elaboration via $readmemh; empty string means no preload.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- addr  in  ADDR_W  request address, sampled at acceptance.
- mem_req  in  1  request strobe from core.
- we  in  1  1 = write, 0 = read; sampled at acceptance.
- data_in  in  DATA_W  write data from core, sampled at acceptance.
- data_out  out  DATA_W  read data, registered.
- mem_ready  out  1  completion strobe.
- load_we  in  1  backdoor write enable.
- load_addr  in  ADDR_W  backdoor address.
- load_data  in  DATA_W  backdoor data.
- prot_err  out  1  write-protect violation flag (see Optional Feature).

Behaviour:
- Reset (edge with rst=1): state=IDLE, wait counter=0, mem_ready=0, data_out=0, prot_err=0. Array contents NOT cleared. Any pending access is abandoned: no write occurs, no mem_ready issued.
- States: IDLE, WAIT.
- IDLE, mem_req=1 at edge k: latch addr/we/data_in.
  - LATENCY=0: perform access at edge k, mem_ready=1 after edge k, remain IDLE.
  - LATENCY>0: counter=LATENCY-1, go to WAIT, mem_ready=0.
- IDLE, mem_req=0: mem_ready=0.
- WAIT: mem_req ignored. Each edge: if counter=0, perform access, set mem_ready=1, return to IDLE; otherwise decrement counter. For an acceptance at edge k, mem_ready is high only after edge k+LATENCY.
- Access:
  - Write stores the latched data_in at the latched addr.
  - data_out = array[addr] after the write, so a write echoes the written data.
  - A read updates data_out only.
  - data_out holds its value until the next completion.
- mem_ready is high for exactly one cycle per completion, except with LATENCY=0 and mem_req held high, where every edge is a new access and mem_ready stays high. For a single access, the core drops mem_req in the cycle mem_ready is high.
- Out of range (addr >= DEPTH): read returns 0; write is dropped; mem_ready is still issued.
- Backdoor: load_we=1 at an edge writes load_data to load_addr in any state, including during reset. Out-of-range backdoor writes are dropped. If a front-door write completes at the same edge and address, the front-door data wins.
- Backdoor/read collision: a front-door read completing at the same edge returns the pre-edge contents.

Optional Feature:
- Macro: MEM_RESPONDER_WRITE_PROT_EN.
- Defined:
  - Adds parameters PROT_LO (default 0) and PROT_HI (default 31).
  - A front-door write with PROT_LO <= addr <= PROT_HI is dropped. mem_ready still pulses, with prot_err=1 in the same cycle only. data_out returns the unchanged contents.
  - Backdoor writes are never protected.
- Undefined: prot_err is tied 0; all in-range writes are performed.

Test Plan:
- Backdoor load 0x00=0x40, 0xE0=0x01. Read 0xE0 with LATENCY=0 -> mem_ready high the cycle after the request edge, data_out=0x01.
- LATENCY=3: write 0xA5 to 0x10, then read 0x10 -> each mem_ready rises exactly 3 edges after acceptance, with one-cycle pulses. Write echoes 0xA5; read returns 0xA5. mem_req toggling during WAIT has no effect.
- rst asserted during WAIT of a write of 0x5A to 0x20 (prior contents 0x11) -> no mem_ready. Subsequent read of 0x20 returns 0x11. data_out=0 immediately after reset.
- DEPTH=200: read 0xF0 returns 0x00 with mem_ready. Write 0xFF to 0xF0 is dropped. Address 0xC7 works normally.
- Same edge: front-door write 0x33 and backdoor write 0x44 to 0x08 -> 0x08 holds 0x33.
- With MEM_RESPONDER_WRITE_PROT_EN, PROT 0..31: write 0x77 to 0x05 -> prot_err=1 with mem_ready, contents unchanged. Write to 0x40 -> prot_err=0, write performed.

Source files
------------

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/ready bus between the eightbit core (master) and mem_responder
// (slave), plus the backdoor program-load port and the write-protect flag.
//
// Signals:
//   addr      master->slave  ADDR_W  request address
//   mem_req   master->slave  1       request strobe
//   we        master->slave  1       1 = write, 0 = read
//   data_in   master->slave  DATA_W  write data
//   data_out  slave->master  DATA_W  registered read / echo data
//   mem_ready slave->master  1       completion strobe
//   load_we   master->slave  1       backdoor write enable
//   load_addr master->slave  ADDR_W  backdoor address
//   load_data master->slave  DATA_W  backdoor data
//   prot_err  slave->master  1       write-protect violation flag
// ---------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] addr;
    logic              mem_req;
    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              mem_ready;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              prot_err;

    modport master (
        output addr, mem_req, we, data_in, load_we, load_addr, load_data,
        input  data_out, mem_ready, prot_err
    );

    modport slave (
        input  addr, mem_req, we, data_in, load_we, load_addr, load_data,
        output data_out, mem_ready, prot_err
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-port synchronous memory slave for the eightbit core's request/ready
// bus, with configurable wait-state latency and a backdoor load port.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset (array contents are kept)
//   bus  mem_responder_if.slave: front-door request bus, backdoor load
//        port, data_out / mem_ready / prot_err responses (all registered)
//
// Optional feature: define MEM_RESPONDER_WRITE_PROT_EN to add the PROT_LO /
// PROT_HI parameters; front-door writes inside [PROT_LO, PROT_HI] are then
// dropped and flagged on prot_err together with mem_ready. Without the macro
// prot_err is constant 0.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int    DATA_W    = 8,
    parameter int    ADDR_W    = 8,
    parameter int    DEPTH     = 256,
    parameter int    LATENCY   = 0,
    parameter string INIT_FILE = ""
`ifdef MEM_RESPONDER_WRITE_PROT_EN
    ,
    parameter int    PROT_LO   = 0,
    parameter int    PROT_HI   = 31
`endif
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter reload on acceptance: WAIT lasts LATENCY edges in total.
    localparam logic [3:0] LAT_RELOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic [ADDR_W-1:0] lat_addr_r;
    logic              lat_we_r;
    logic [DATA_W-1:0] lat_data_r;
    logic [DATA_W-1:0] data_out_r;
    logic              mem_ready_r;
    logic              prot_err_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              accept_s;
    logic              acc_s;
    logic              acc_we_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_data_s;
    logic              acc_in_range_s;
    logic              prot_hit_s;
    logic              fd_wr_s;
    logic              bd_wr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [IDX_W-1:0]  acc_idx_s;
    logic [IDX_W-1:0]  load_idx_s;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
    endfunction

    // Next-state logic and selection of the access performed at this edge.
    // With LATENCY=0 the access uses the live bus inputs; otherwise it uses
    // the values latched at acceptance.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        accept_s   = 1'b0;
        acc_s      = 1'b0;
        acc_we_s   = lat_we_r;
        acc_addr_s = lat_addr_r;
        acc_data_s = lat_data_r;
        case (state_r)
            IDLE: begin
                if (bus.mem_req) begin
                    accept_s = 1'b1;
                    if (LATENCY == 0) begin
                        acc_s      = 1'b1;
                        acc_we_s   = bus.we;
                        acc_addr_s = bus.addr;
                        acc_data_s = bus.data_in;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = LAT_RELOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    acc_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Address decode, protection check and the data presented on completion.
    always_comb begin
        acc_in_range_s = addr_in_range(acc_addr_s);
        acc_idx_s      = acc_addr_s[IDX_W-1:0];
        load_idx_s     = bus.load_addr[IDX_W-1:0];
`ifdef MEM_RESPONDER_WRITE_PROT_EN
        prot_hit_s = acc_we_s &&
                     ({1'b0, acc_addr_s} >= (ADDR_W + 1)'(PROT_LO)) &&
                     ({1'b0, acc_addr_s} <= (ADDR_W + 1)'(PROT_HI));
`else
        prot_hit_s = 1'b0;
`endif
        // A pending access is abandoned by reset, so no front-door write then.
        fd_wr_s = acc_s && !rst && acc_we_s && acc_in_range_s && !prot_hit_s;
        bd_wr_s = bus.load_we && addr_in_range(bus.load_addr);
        // Writes echo the stored data; reads (and dropped writes) return the
        // pre-edge contents, so a colliding backdoor write is not visible yet.
        if (fd_wr_s) begin
            rd_data_s = acc_data_s;
        end else if (acc_in_range_s) begin
            rd_data_s = mem_r[acc_idx_s];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Memory array: backdoor first so a same-address front-door write wins.
    always_ff @(posedge clk) begin
        if (bd_wr_s) begin
            mem_r[load_idx_s] <= bus.load_data;
        end
        if (fd_wr_s) begin
            mem_r[acc_idx_s] <= acc_data_s;
        end
    end

    // Control state, request latches and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            lat_addr_r  <= {ADDR_W{1'b0}};
            lat_we_r    <= 1'b0;
            lat_data_r  <= {DATA_W{1'b0}};
            data_out_r  <= {DATA_W{1'b0}};
            mem_ready_r <= 1'b0;
            prot_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_ready_r <= acc_s;
            prot_err_r  <= acc_s && prot_hit_s;
            if (accept_s) begin
                lat_addr_r <= bus.addr;
                lat_we_r   <= bus.we;
                lat_data_r <= bus.data_in;
            end else begin
                lat_addr_r <= lat_addr_r;
                lat_we_r   <= lat_we_r;
                lat_data_r <= lat_data_r;
            end
            if (acc_s) begin
                data_out_r <= rd_data_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.prot_err  = prot_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Scoreboard bench for mem_responder. Three instances run side by side:
//   u0: LATENCY=0, DEPTH=256     u1: LATENCY=3, DEPTH=256
//   u2: LATENCY=0, DEPTH=200     u3: write-protected (only with the macro)
// Stimulus pushes the expected data / prot_err / completion edge into a
// queue; a negedge monitor pops and compares whenever mem_ready is high.
// ---------------------------------------------------------------------------
module tb_mem_responder;
`ifdef MEM_RESPONDER_WRITE_PROT_EN
    localparam int NDUT = 4;
`else
    localparam int NDUT = 3;
`endif

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       prot;
        longint     cyc;
    } exp_t;

    logic   clk = 1'b0;
    longint edges = 0;
    int     checks = 0;
    int     errors = 0;
    exp_t   sb[$];

    logic       rst_v  [4];
    logic [7:0] addr_v [4];
    logic       req_v  [4];
    logic       we_v   [4];
    logic [7:0] din_v  [4];
    logic       lwe_v  [4];
    logic [7:0] laddr_v[4];
    logic [7:0] ldata_v[4];
    logic [7:0] dout_w [4];
    logic       rdy_w  [4];
    logic       perr_w [4];

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) if1 ();
    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) if2 ();
    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) if3 ();

    assign if0.addr = addr_v[0];  assign if0.mem_req = req_v[0];  assign if0.we = we_v[0];
    assign if0.data_in = din_v[0]; assign if0.load_we = lwe_v[0];
    assign if0.load_addr = laddr_v[0]; assign if0.load_data = ldata_v[0];
    assign if1.addr = addr_v[1];  assign if1.mem_req = req_v[1];  assign if1.we = we_v[1];
    assign if1.data_in = din_v[1]; assign if1.load_we = lwe_v[1];
    assign if1.load_addr = laddr_v[1]; assign if1.load_data = ldata_v[1];
    assign if2.addr = addr_v[2];  assign if2.mem_req = req_v[2];  assign if2.we = we_v[2];
    assign if2.data_in = din_v[2]; assign if2.load_we = lwe_v[2];
    assign if2.load_addr = laddr_v[2]; assign if2.load_data = ldata_v[2];
    assign if3.addr = addr_v[3];  assign if3.mem_req = req_v[3];  assign if3.we = we_v[3];
    assign if3.data_in = din_v[3]; assign if3.load_we = lwe_v[3];
    assign if3.load_addr = laddr_v[3]; assign if3.load_data = ldata_v[3];

    assign dout_w[0] = if0.data_out; assign rdy_w[0] = if0.mem_ready; assign perr_w[0] = if0.prot_err;
    assign dout_w[1] = if1.data_out; assign rdy_w[1] = if1.mem_ready; assign perr_w[1] = if1.prot_err;
    assign dout_w[2] = if2.data_out; assign rdy_w[2] = if2.mem_ready; assign perr_w[2] = if2.prot_err;

    mem_responder #(.LATENCY(0)
`ifdef MEM_RESPONDER_WRITE_PROT_EN
        , .PROT_LO(255), .PROT_HI(0)
`endif
    ) u0 (.clk(clk), .rst(rst_v[0]), .bus(if0));

    mem_responder #(.LATENCY(3)
`ifdef MEM_RESPONDER_WRITE_PROT_EN
        , .PROT_LO(255), .PROT_HI(0)
`endif
    ) u1 (.clk(clk), .rst(rst_v[1]), .bus(if1));

    mem_responder #(.LATENCY(0), .DEPTH(200)
`ifdef MEM_RESPONDER_WRITE_PROT_EN
        , .PROT_LO(255), .PROT_HI(0)
`endif
    ) u2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

`ifdef MEM_RESPONDER_WRITE_PROT_EN
    mem_responder #(.LATENCY(0), .PROT_LO(0), .PROT_HI(31))
        u3 (.clk(clk), .rst(rst_v[3]), .bus(if3));
    assign dout_w[3] = if3.data_out; assign rdy_w[3] = if3.mem_ready; assign perr_w[3] = if3.prot_err;
`else
    assign if3.data_out = 8'h00; assign if3.mem_ready = 1'b0; assign if3.prot_err = 1'b0;
    assign dout_w[3] = 8'h00; assign rdy_w[3] = 1'b0; assign perr_w[3] = 1'b0;
`endif

    // Monitor: every mem_ready pulse must match the oldest expectation of its DUT.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rdy_w[d] === 1'b1) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].dut == d) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_ready dut%0d: mem_ready=1 at edge %0d, required no completion", d, edges);
                end else begin
                    if (dout_w[d] !== sb[idx].data) begin
                        errors++;
                        $display("FAIL data dut%0d: got %h required %h", d, dout_w[d], sb[idx].data);
                    end
                    checks++;
                    if (edges != sb[idx].cyc) begin
                        errors++;
                        $display("FAIL ready_edge dut%0d: got edge %0d required %0d", d, edges, sb[idx].cyc);
                    end
                    checks++;
                    if (perr_w[d] !== sb[idx].prot) begin
                        errors++;
                        $display("FAIL prot_err dut%0d: got %b required %b", d, perr_w[d], sb[idx].prot);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    function automatic int pending(input int d);
        int n;
        n = 0;
        foreach (sb[i]) if (sb[i].dut == d) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Bounded wait for all outstanding completions of one DUT.
    task automatic wait_done(input int d);
        for (int i = 0; i < 40 && pending(d) > 0; i++) @(negedge clk);
        checks++;
        if (pending(d) > 0) begin
            errors++;
            $display("FAIL timeout dut%0d: %0d completions outstanding, required 0", d, pending(d));
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) sb.delete(i);
        end
    endtask

    task automatic bd(input int d, input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        lwe_v[d] = 1'b1; laddr_v[d] = a; ldata_v[d] = v;
        @(negedge clk);
        lwe_v[d] = 1'b0;
    endtask

    // One front-door access; during WAIT mem_req toggles with a bogus write.
    task automatic fd(input int d, input logic w, input logic [7:0] a, input logic [7:0] v,
                      input logic [7:0] expd, input logic pe, input int lat);
        @(negedge clk);
        addr_v[d] = a; we_v[d] = w; din_v[d] = v; req_v[d] = 1'b1;
        sb.push_back('{d, expd, pe, edges + 1 + lat});
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            req_v[d] = (i % 2 == 1); addr_v[d] = 8'h10; we_v[d] = 1'b1; din_v[d] = 8'hEE;
        end
        @(negedge clk);
        req_v[d] = 1'b0; we_v[d] = 1'b0;
        wait_done(d);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst_v[d] = 1'b1; addr_v[d] = 8'h00; req_v[d] = 1'b0; we_v[d] = 1'b0;
            din_v[d] = 8'h00; lwe_v[d] = 1'b0; laddr_v[d] = 8'h00; ldata_v[d] = 8'h00;
        end
        // Backdoor load while still in reset.
        bd(0, 8'h00, 8'h40);
        bd(0, 8'hE0, 8'h01);
        @(negedge clk);
        for (int d = 0; d < 4; d++) rst_v[d] = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset_data_out_dut%0d", d), dout_w[d], 8'h00);
            chk($sformatf("reset_ready_dut%0d", d), {7'd0, rdy_w[d]}, 8'h00);
        end

        // LATENCY=0 basics, held mem_req, same-edge backdoor collisions.
        fd(0, 1'b0, 8'hE0, 8'h00, 8'h01, 1'b0, 0);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h00;
        sb.push_back('{0, 8'h40, 1'b0, edges + 1});
        @(negedge clk);
        addr_v[0] = 8'hE0;
        sb.push_back('{0, 8'h01, 1'b0, edges + 1});
        @(negedge clk);
        req_v[0] = 1'b0;
        wait_done(0);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h08; din_v[0] = 8'h33;
        lwe_v[0] = 1'b1; laddr_v[0] = 8'h08; ldata_v[0] = 8'h44;
        sb.push_back('{0, 8'h33, 1'b0, edges + 1});
        @(negedge clk);
        req_v[0] = 1'b0; we_v[0] = 1'b0; lwe_v[0] = 1'b0;
        wait_done(0);
        fd(0, 1'b0, 8'h08, 8'h00, 8'h33, 1'b0, 0);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'hE0;
        lwe_v[0] = 1'b1; laddr_v[0] = 8'hE0; ldata_v[0] = 8'h55;
        sb.push_back('{0, 8'h01, 1'b0, edges + 1});
        @(negedge clk);
        req_v[0] = 1'b0; lwe_v[0] = 1'b0;
        wait_done(0);
        fd(0, 1'b0, 8'hE0, 8'h00, 8'h55, 1'b0, 0);

        // LATENCY=3 write/read with mem_req toggling during WAIT.
        fd(1, 1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, 3);
        fd(1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3);

        // Reset during WAIT abandons the write.
        bd(1, 8'h20, 8'h11);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 8'h20; din_v[1] = 8'h5A;
        @(negedge clk);
        req_v[1] = 1'b0; we_v[1] = 1'b0; rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        chk("wait_reset_data_out", dout_w[1], 8'h00);
        chk("wait_reset_ready", {7'd0, rdy_w[1]}, 8'h00);
        repeat (6) @(negedge clk);
        fd(1, 1'b0, 8'h20, 8'h00, 8'h11, 1'b0, 3);

        // DEPTH=200 out-of-range handling and last valid word.
        fd(2, 1'b0, 8'hF0, 8'h00, 8'h00, 1'b0, 0);
        fd(2, 1'b1, 8'hF0, 8'hFF, 8'h00, 1'b0, 0);
        fd(2, 1'b0, 8'hF0, 8'h00, 8'h00, 1'b0, 0);
        fd(2, 1'b1, 8'hC7, 8'h3C, 8'h3C, 1'b0, 0);
        fd(2, 1'b0, 8'hC7, 8'h00, 8'h3C, 1'b0, 0);

`ifdef MEM_RESPONDER_WRITE_PROT_EN
        @(negedge clk);
        rst_v[3] = 1'b0;
        bd(3, 8'h05, 8'h12);
        fd(3, 1'b1, 8'h05, 8'h77, 8'h12, 1'b1, 0);
        fd(3, 1'b0, 8'h05, 8'h00, 8'h12, 1'b0, 0);
        fd(3, 1'b1, 8'h40, 8'h66, 8'h66, 1'b0, 0);
        fd(3, 1'b0, 8'h40, 8'h00, 8'h66, 1'b0, 0);
`endif

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d queued expectations, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
